// File: rtl/can_pkg.sv
// Shared CAN definitions: error-frame FSM encoding, error-frame field lengths
// and frame-field codes common to the TX block and the error monitors.
package can_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLAG     = 2'd1,
    ST_WAIT_REC = 2'd2,
    ST_DELIM    = 2'd3
  } err_state_e;

  localparam int unsigned ERR_FLAG_BITS  = 6;
  localparam int unsigned ERR_DELIM_BITS = 8;

  // Frame-field codes reported by the monitors
  localparam logic [4:0] FIELD_CRC_DELIM = 5'b10001;
  localparam logic [4:0] FIELD_ACK_DELIM = 5'b10010;

endpackage

// File: rtl/can_bit_timer.sv
// Nominal bit timer: free-running 0..CLKS_PER_BIT-1 counter with synchronous
// clear, decoded into sample-point and bit-end strobes.
module can_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_POINT = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_sample_c,
  output logic o_bit_end_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clr || (cnt_q == CNT_W'(CLKS_PER_BIT - 1))) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_sample_c  = (cnt_q == CNT_W'(SAMPLE_POINT));
  assign o_bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/can_error_frame_tx.sv
// CAN error-frame transmitter: sends the active/passive error flag, waits for a
// recessive bus, then sends the 8-bit recessive error delimiter.
module can_error_frame_tx
  import can_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_POINT = 7,
  parameter int unsigned MAX_DOM_WAIT = 14
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Error,
  input  logic i_Error_Passive,
  input  logic i_Rx_Data,
  output logic o_Tx_Data,
  output logic o_Busy,
  output logic o_Done,
  output logic o_Flag_Bit_Error,
  output logic o_Stuck_Dominant
);

  localparam int unsigned FLAG_W  = $clog2(ERR_FLAG_BITS);
  localparam int unsigned DELIM_W = $clog2(ERR_DELIM_BITS + 1);
  localparam int unsigned DOM_W   = $clog2(MAX_DOM_WAIT + 1);

  err_state_e         state_q, state_d;
  logic [FLAG_W-1:0]  flag_cnt_q, flag_cnt_d;
  logic [DELIM_W-1:0] delim_cnt_q, delim_cnt_d;
  logic [DOM_W-1:0]   dom_cnt_q, dom_cnt_d;
  logic               passive_q, passive_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               flag_err_q, flag_err_d;
  logic               stuck_q, stuck_d;

  logic sample_c;
  logic bit_end_c;
  logic timer_clr_c;

  // Timer held at zero in IDLE and restarted on every state entry
  assign timer_clr_c = (state_q == ST_IDLE) || (state_d != state_q);

  can_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_bit_timer (
    .clk         (i_Clock),
    .rst_n       (i_Reset_n),
    .i_clr       (timer_clr_c),
    .o_sample_c  (sample_c),
    .o_bit_end_c (bit_end_c)
  );

  always_comb begin
    state_d     = state_q;
    flag_cnt_d  = flag_cnt_q;
    delim_cnt_d = delim_cnt_q;
    dom_cnt_d   = dom_cnt_q;
    passive_d   = passive_q;
    done_d      = 1'b0;
    flag_err_d  = 1'b0;
    stuck_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Error) begin
          state_d    = ST_FLAG;
          passive_d  = i_Error_Passive;
          flag_cnt_d = '0;
        end
      end

      ST_FLAG: begin
        if (sample_c && !passive_q && i_Rx_Data) begin
          flag_err_d = 1'b1;
        end
        if (bit_end_c) begin
          if (flag_cnt_q == FLAG_W'(ERR_FLAG_BITS - 1)) begin
            state_d     = ST_WAIT_REC;
            dom_cnt_d   = '0;
            delim_cnt_d = '0;
          end else begin
            flag_cnt_d = flag_cnt_q + FLAG_W'(1);
          end
        end
      end

      // A non-zero delimiter count marks that this bit was read recessive
      ST_WAIT_REC: begin
        if (sample_c) begin
          if (i_Rx_Data) begin
            delim_cnt_d = DELIM_W'(1);
          end else if (dom_cnt_q != DOM_W'(MAX_DOM_WAIT)) begin
            dom_cnt_d = dom_cnt_q + DOM_W'(1);
            stuck_d   = (dom_cnt_q == DOM_W'(MAX_DOM_WAIT - 1));
          end
        end
        if (bit_end_c && (delim_cnt_q != '0)) begin
          state_d     = ST_DELIM;
          delim_cnt_d = delim_cnt_q + DELIM_W'(1);
        end
      end

      ST_DELIM: begin
        if (sample_c && !i_Rx_Data) begin
          state_d     = ST_FLAG;
          flag_cnt_d  = '0;
          delim_cnt_d = '0;
        end else if (bit_end_c) begin
          if (delim_cnt_q == DELIM_W'(ERR_DELIM_BITS)) begin
            state_d     = ST_IDLE;
            delim_cnt_d = '0;
            done_d      = 1'b1;
          end else begin
            delim_cnt_d = delim_cnt_q + DELIM_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    tx_d   = !((state_d == ST_FLAG) && !passive_d);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= ST_IDLE;
      flag_cnt_q  <= '0;
      delim_cnt_q <= '0;
      dom_cnt_q   <= '0;
      passive_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      flag_err_q  <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_cnt_q  <= flag_cnt_d;
      delim_cnt_q <= delim_cnt_d;
      dom_cnt_q   <= dom_cnt_d;
      passive_q   <= passive_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      flag_err_q  <= flag_err_d;
      stuck_q     <= stuck_d;
    end
  end

  assign o_Tx_Data        = tx_q;
  assign o_Busy           = busy_q;
  assign o_Done           = done_q;
  assign o_Flag_Bit_Error = flag_err_q;
  assign o_Stuck_Dominant = stuck_q;

endmodule
